// File: rtl/lms_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lms_fifo_pkg
// Purpose  : Shared types and constants for the LMS FIFO read-side sequencer:
//            FSM state encoding, skid buffer geometry, frame counter width.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package lms_fifo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int SKID_DEPTH  = 4;
  localparam int SKID_PTR_W  = $clog2(SKID_DEPTH);
  // One extra bit so the occupancy can represent a completely full buffer.
  localparam int SKID_OCC_W  = SKID_PTR_W + 1;
  localparam int FRAME_CNT_W = 16;

endpackage
`default_nettype wire

// File: rtl/lms_skid_buf.sv
`default_nettype none
// ============================================================================
// Module   : lms_skid_buf
// Purpose  : 4-entry circular buffer that absorbs FIFO read latency. The
//            caller guarantees no write when full and no read when empty.
// Ports    : clk, rst_n     - clock, async active-low reset
//            wr, wr_data    - push one word
//            rd             - pop the head word
//            occ            - number of stored words (0..SKID_DEPTH)
//            head           - word at the read pointer
// Revision : 1.0 - initial release
// ============================================================================
module lms_skid_buf
  import lms_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd,
  output logic [SKID_OCC_W-1:0] occ,
  output logic [DATA_WIDTH-1:0] head
);

  logic [DATA_WIDTH-1:0] mem [SKID_DEPTH];
  logic [SKID_PTR_W-1:0] wr_ptr;
  logic [SKID_PTR_W-1:0] rd_ptr;

  // Storage is cleared on reset so the head reads as zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SKID_DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (wr) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + 1'b1;   // wraps modulo SKID_DEPTH
      end
      if (rd) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr, rd})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;            // idle or simultaneous push/pop
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule
`default_nettype wire

// File: rtl/lms_fifo_rd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lms_fifo_rd_ctrl
// Purpose  : Read-side frame sequencer for the LMS sample FIFO. Waits for a
//            full frame in the FIFO, issues FRAME_LEN reads under a credit
//            limit, and streams the returned words to the LMS core.
// Ports    : clk, rst_n                 - read clock, async active-low reset
//            enable                     - permission to start new frames
//            fifo_rd_water_level        - FIFO fill level
//            fifo_empty                 - FIFO empty flag
//            fifo_rd_en, fifo_rd_data   - FIFO read port
//            m_valid, m_ready, m_data,
//            m_last                     - stream to the LMS core
//            busy, frame_done, frame_cnt- status
// Revision : 1.0 - initial release
// ============================================================================
module lms_fifo_rd_ctrl
  import lms_fifo_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WIDTH = 10,
  parameter int FRAME_LEN   = 64,
  parameter int RD_LATENCY  = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic [DEPTH_WIDTH:0]   fifo_rd_water_level,
  input  logic                   fifo_empty,
  output logic                   fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]  fifo_rd_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [DATA_WIDTH-1:0]  m_data,
  output logic                   m_last,
  output logic                   busy,
  output logic                   frame_done,
  output logic [FRAME_CNT_W-1:0] frame_cnt
);

  // Beat counters must hold FRAME_LEN itself, up to 2^DEPTH_WIDTH.
  localparam int                  CNT_W       = DEPTH_WIDTH + 1;
  localparam logic [CNT_W-1:0]    FRAME_LEN_C = CNT_W'(FRAME_LEN);
  localparam logic [CNT_W-1:0]    LAST_IDX_C  = CNT_W'(FRAME_LEN - 1);
  localparam logic [SKID_OCC_W:0] CREDIT_C    = (SKID_OCC_W + 1)'(SKID_DEPTH);

  state_t                  state;
  state_t                  state_nxt;
  logic                    clr;
  logic [CNT_W-1:0]        issued;
  logic [CNT_W-1:0]        sent;
  logic [SKID_OCC_W-1:0]   inflight;
  logic [SKID_OCC_W-1:0]   occ;
  logic [SKID_OCC_W:0]     credit_used;
  logic [RD_LATENCY-1:0]   rd_pipe;
  logic                    ret;
  logic                    xfer;

  // ---------------------------------------------------------------- stream
  assign m_valid     = (occ != '0);
  assign m_last      = m_valid && (sent == LAST_IDX_C);
  assign xfer        = m_valid && m_ready;

  // Words already requested plus words already buffered may never exceed
  // the buffer depth, so a returning word always has a free slot.
  assign credit_used = {1'b0, inflight} + {1'b0, occ};

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    clr        = 1'b0;
    fifo_rd_en = 1'b0;
    busy       = (state != ST_IDLE);
    frame_done = (state == ST_DONE);
    case (state)
      ST_IDLE: begin
        if (enable && (fifo_rd_water_level >= FRAME_LEN_C)) begin
          state_nxt = ST_BURST;
          clr       = 1'b1;
        end
      end
      ST_BURST: begin
        fifo_rd_en = (issued < FRAME_LEN_C) && !fifo_empty &&
                     (credit_used < CREDIT_C);
        if (xfer && m_last) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------- read latency
  // Delays each read strobe by RD_LATENCY cycles so it lines up with the
  // cycle in which the FIFO presents the corresponding word.
  generate
    if (RD_LATENCY == 1) begin : g_lat_one
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rd_pipe <= '0;
        end else begin
          rd_pipe <= fifo_rd_en;
        end
      end
    end else begin : g_lat_multi
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rd_pipe <= '0;
        end else begin
          rd_pipe <= {rd_pipe[RD_LATENCY-2:0], fifo_rd_en};
        end
      end
    end
  endgenerate

  assign ret = rd_pipe[RD_LATENCY-1];

  // ---------------------------------------------------------------- counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issued    <= '0;
      sent      <= '0;
      inflight  <= '0;
      frame_cnt <= '0;
    end else begin
      if (clr) begin
        issued <= '0;
        sent   <= '0;
      end else begin
        if (fifo_rd_en) begin
          issued <= issued + 1'b1;
        end
        if (xfer) begin
          sent <= sent + 1'b1;
        end
      end

      // A word stays in flight until the cycle it is written to the buffer.
      case ({fifo_rd_en, ret})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase

      // Counted on the final transfer so DONE already shows the new count.
      if (xfer && m_last) begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------- buffer
  lms_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr      (ret),
    .wr_data (fifo_rd_data),
    .rd      (xfer),
    .occ     (occ),
    .head    (m_data)
  );

endmodule
`default_nettype wire

// File: tb/tb_lms_fifo_rd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_lms_fifo_rd_ctrl
// Purpose  : Self-checking bench for lms_fifo_rd_ctrl. Two lanes run the same
//            stimulus, one with RD_LATENCY=1 and one with RD_LATENCY=2, each
//            with its own queue-based FIFO model and stream scoreboard.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_lms_fifo_rd_ctrl;

  localparam int FL = 8;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic          empty_force;
  logic          push_stb;
  logic [DW-1:0] push_val;
  logic          preload_cnt;
  logic          m_ready = 1'b1;
  int            ready_mode = 0;
  int            cyc = 0;
  int            n_checks = 0;
  int            n_errs = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Sink readiness: constantly ready, or a 50% random pattern.
  always @(posedge clk) begin
    m_ready <= (ready_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- lanes
  for (genvar g = 0; g < 2; g++) begin : g_lane
    localparam int LAT = g + 1;

    logic          fifo_rd_en, m_valid, m_last, busy, frame_done, fifo_empty;
    logic [DW-1:0] m_data, fifo_rd_data;
    logic [DW-1:0] d1 = '0, d2 = '0;
    logic [10:0]   level = '0;
    logic [15:0]   frame_cnt;
    bit            nonempty = 1'b0;
    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] exp_q[$];

    lms_fifo_rd_ctrl #(
      .DATA_WIDTH  (DW),
      .DEPTH_WIDTH (10),
      .FRAME_LEN   (FL),
      .RD_LATENCY  (LAT)
    ) dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .enable              (enable),
      .fifo_rd_water_level (level),
      .fifo_empty          (fifo_empty),
      .fifo_rd_en          (fifo_rd_en),
      .fifo_rd_data        (fifo_rd_data),
      .m_valid             (m_valid),
      .m_ready             (m_ready),
      .m_data              (m_data),
      .m_last              (m_last),
      .busy                (busy),
      .frame_done          (frame_done),
      .frame_cnt           (frame_cnt)
    );

    assign fifo_empty   = !nonempty || empty_force;
    assign fifo_rd_data = (LAT == 1) ? d1 : d2;

    // FIFO model: words leave in push order; d2 is the optional output register.
    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        fifo_q.delete();
        exp_q.delete();
        level    <= '0;
        nonempty <= 1'b0;
        d1       <= '0;
        d2       <= '0;
      end else begin
        if (fifo_rd_en) begin
          if (fifo_q.size() > 0) d1 <= fifo_q.pop_front();
          else                   d1 <= 32'hDEADBEEF;
        end
        d2 <= d1;
        if (push_stb) begin
          fifo_q.push_back(push_val);
          exp_q.push_back(push_val);
        end
        level    <= 11'(fifo_q.size());
        nonempty <= (fifo_q.size() != 0);
      end
    end

    // Every reset assertion must drive the outputs to their idle values at once.
    always @(negedge rst_n) begin
      #1;
      check_val("rst_rd_en", fifo_rd_en, 0);
      check_val("rst_valid", m_valid, 0);
      check_val("rst_last", m_last, 0);
      check_val("rst_busy", busy, 0);
      check_val("rst_done", frame_done, 0);
      check_val("rst_data", m_data, 0);
      check_val("rst_fcnt", frame_cnt, 0);
    end

    // Reference model of the frame protocol, sampled mid-cycle.
    int            beat = 0, dones = 0, rd_total = 0, xfer_total = 0, reads_frame = 0;
    int            start_cyc = 0, first_cyc = -1;
    bit            busy_exp = 0, done_exp = 0, last_xfer = 0, stall = 0, start_now = 0;
    bit            empty_hit = 0, slow = 0, was_busy, was_done;
    logic [DW-1:0] data_prev = '0, exp_d;
    logic [15:0]   cnt_model = '0;

    always @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
        beat = 0; rd_total = 0; xfer_total = 0; reads_frame = 0; first_cyc = -1;
        busy_exp = 0; done_exp = 0; last_xfer = 0; stall = 0; start_now = 0;
        empty_hit = 0; slow = 0; cnt_model = '0;
      end else begin
        was_busy = busy_exp;
        was_done = done_exp;
        done_exp = last_xfer;               // completion pulse follows the last beat
        if (preload_cnt) cnt_model = 16'hFFFF;
        if (done_exp) cnt_model = cnt_model + 16'd1;
        busy_exp = was_busy ? !was_done : start_now;

        check_val("frame_done", frame_done, done_exp);
        check_val("frame_cnt", frame_cnt, cnt_model);
        check_val("busy", busy, busy_exp);

        if (!was_busy && busy_exp) begin
          check_val("first_rd", fifo_rd_en, !fifo_empty);
          reads_frame = 0; first_cyc = -1; empty_hit = 0; slow = 0; start_cyc = cyc;
        end
        if (empty_force && busy_exp) empty_hit = 1;
        if (busy_exp && !m_ready) slow = 1;

        check_val("rd_gate", fifo_rd_en && (!busy_exp || fifo_empty), 0);
        check_val("credit", (rd_total + int'(fifo_rd_en) - xfer_total) <= 4, 1);
        rd_total    += int'(fifo_rd_en);
        reads_frame += int'(fifo_rd_en);

        if (stall) begin
          check_val("hold_valid", m_valid, 1);
          check_val("hold_data", m_data, data_prev);
        end
        if (!busy_exp) check_val("idle_valid", m_valid, 0);
        check_val("last", m_last, m_valid && (beat == FL - 1));

        if (m_valid && first_cyc < 0) begin
          first_cyc = cyc;
          if (!empty_hit) check_val("latency", cyc - start_cyc, 1 + LAT);
        end

        last_xfer = 0;
        if (m_valid && m_ready) begin
          exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hBAD0BAD0;
          check_val("data", m_data, exp_d);
          xfer_total++;
          if (beat == FL - 1) begin
            last_xfer = 1;
            beat      = 0;
            check_val("reads", reads_frame, FL);
            if (!slow && !empty_hit) check_val("tput", cyc - first_cyc, FL - 1);
          end else begin
            beat++;
          end
        end
        stall     = m_valid && !m_ready;
        data_prev = m_data;
        if (done_exp) dones++;
        start_now = !busy_exp && enable && (level >= FL);
      end
    end
  end

  // ---------------------------------------------------------------- stimulus
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_words(input int n, input int base, input bit ramp);
    for (int i = 0; i < n; i++) begin
      push_stb = 1'b1;
      push_val = ramp ? 32'(base + i) : $urandom;
      tick(1);
    end
    push_stb = 1'b0;
  endtask

  task automatic wait_frames(input int target);
    int t = 0;
    while ((g_lane[0].dones < target || g_lane[1].dones < target) && t < 400) begin
      tick(1);
      t++;
    end
    check_val("frame_timeout", t < 400, 1);
  endtask

  task automatic wait_beat0(input int n);
    int t = 0;
    while (g_lane[0].beat < n && t < 200) begin
      tick(1);
      t++;
    end
    check_val("beat_timeout", t < 200, 1);
  endtask

  initial begin
    rst_n = 1'b1; enable = 1'b0; empty_force = 1'b0; push_stb = 1'b0;
    push_val = '0; preload_cnt = 1'b0;
    #2 rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(2);

    // Threshold: seven words buffered must not start a frame.
    enable = 1'b1;
    push_words(7, 0, 1);
    tick(6);
    check_val("thr_busy_l1", g_lane[0].busy, 0);
    check_val("thr_busy_l2", g_lane[1].busy, 0);
    check_val("thr_rd_l1", g_lane[0].fifo_rd_en, 0);
    // Eighth word completes the ramp 0..7 and starts the frame.
    push_words(1, 7, 1);
    wait_frames(1);
    tick(2);
    check_val("t1_fcnt_l1", g_lane[0].frame_cnt, 1);
    check_val("t1_fcnt_l2", g_lane[1].frame_cnt, 1);

    // Random backpressure over three back-to-back frames.
    ready_mode = 1;
    push_words(3 * FL, 0, 0);
    wait_frames(4);
    tick(2);
    ready_mode = 0;

    // Empty window early in the frame, enable dropped at beat 3.
    push_words(FL, 0, 0);
    for (int t = 0; t < 50 && !g_lane[0].busy; t++) tick(1);
    tick(1);
    empty_force = 1'b1;
    tick(3);
    empty_force = 1'b0;
    wait_beat0(3);
    enable = 1'b0;
    wait_frames(5);
    push_words(FL, 0, 0);
    tick(20);
    check_val("no_restart_l1", g_lane[0].busy, 0);
    check_val("no_restart_l2", g_lane[1].busy, 0);
    enable = 1'b1;
    wait_frames(6);
    tick(2);

    // Reset in the middle of a frame; FIFO model resets with it.
    push_words(FL, 0, 0);
    wait_beat0(4);
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
    push_words(FL, 100, 1);
    wait_frames(7);
    tick(2);
    check_val("post_rst_fcnt_l1", g_lane[0].frame_cnt, 1);
    check_val("post_rst_fcnt_l2", g_lane[1].frame_cnt, 1);

    // Frame counter wrap from 0xFFFF.
    preload_cnt = 1'b1;
    force g_lane[0].dut.frame_cnt = 16'hFFFF;
    force g_lane[1].dut.frame_cnt = 16'hFFFF;
    tick(1);
    release g_lane[0].dut.frame_cnt;
    release g_lane[1].dut.frame_cnt;
    preload_cnt = 1'b0;
    push_words(FL, 0, 0);
    wait_frames(8);
    tick(2);
    check_val("wrap_l1", g_lane[0].frame_cnt, 0);
    check_val("wrap_l2", g_lane[1].frame_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
`default_nettype wire
